// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
//   Last stage of the core. Takes one retired result from execute and either
//   writes it to the register file (optionally followed by a second write of
//   the high half to a special destination), or issues it to memory as a
//   store and waits for the ack. A RET-class kill parks the unit in a sticky
//   halt until reset. Keeps a retired-instruction count and the RIP of the
//   most recently retired instruction.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   validIn / readyOut          result handshake (transfer = validIn && readyOut)
//   aluResultIn                 primary result
//   aluResultSpecialIn          high half of a MUL/IMUL product
//   destRegIn                   primary destination GPR
//   destRegSpecialIn            special destination GPR
//   destRegSpecialValidIn       a special write is required
//   isMemoryAccessDestIn        primary result goes to memory
//   memoryAddressDestIn         store address
//   killIn                      RET/RETF/IRET: halt the core
//   currentRipIn                RIP of the incoming instruction
//   regWriteEnOut/AddrOut/DataOut  register-file write port
//   storeReqOut/AddrOut/DataOut    store request, held until storeAckIn
//   storeAckIn                  memory accepted the store
//   haltOut                     sticky halt
//   retiredCountOut             retired-instruction count (wraps)
//   retiredRipOut               RIP of the last retired instruction
//
// Every output is a flop. The combinational block computes the next state
// and the value each output takes in that next state; the sequential block
// just loads them.
// ---------------------------------------------------------------------------
module writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        validIn,
  output logic        readyOut,
  input  logic [63:0] aluResultIn,
  input  logic [63:0] aluResultSpecialIn,
  input  logic [3:0]  destRegIn,
  input  logic [3:0]  destRegSpecialIn,
  input  logic        destRegSpecialValidIn,
  input  logic        isMemoryAccessDestIn,
  input  logic [63:0] memoryAddressDestIn,
  input  logic        killIn,
  input  logic [63:0] currentRipIn,
  output logic        regWriteEnOut,
  output logic [3:0]  regWriteAddrOut,
  output logic [63:0] regWriteDataOut,
  output logic        storeReqOut,
  output logic [63:0] storeAddrOut,
  output logic [63:0] storeDataOut,
  input  logic        storeAckIn,
  output logic        haltOut,
  output logic [63:0] retiredCountOut,
  output logic [63:0] retiredRipOut
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_MAIN    = 3'd1,
    WR_SPECIAL = 3'd2,
    STORE      = 3'd3,
    HALTED     = 3'd4
  } state_t;

  state_t state, stateNext, dispatchState;

  // Holding registers for the instruction in flight.
  logic [3:0]  hDestReg, hDestRegSpecial;
  logic        hSpecValid;
  logic [63:0] hAluResult, hAluResultSpecial, hMemAddr, hRip;

  logic accept;
  logic retireHeld;   // held instruction finishes this cycle
  logic retireKill;   // incoming kill retires on its accept edge

  // Fields as they will be seen next cycle: fresh inputs on accept,
  // otherwise whatever is already held.
  logic [3:0]  nDestReg, nDestRegSpecial;
  logic        nSpecValid;
  logic [63:0] nAluResult, nAluResultSpecial, nMemAddr;

  logic        readyNext, wrEnNext, storeReqNext, haltNext;
  logic [3:0]  wrAddrNext;
  logic [63:0] wrDataNext, storeAddrNext, storeDataNext, countNext, ripNext;

  assign accept = validIn && readyOut;

  assign nDestReg          = accept ? destRegIn             : hDestReg;
  assign nDestRegSpecial   = accept ? destRegSpecialIn      : hDestRegSpecial;
  assign nSpecValid        = accept ? destRegSpecialValidIn : hSpecValid;
  assign nAluResult        = accept ? aluResultIn           : hAluResult;
  assign nAluResultSpecial = accept ? aluResultSpecialIn    : hAluResultSpecial;
  assign nMemAddr          = accept ? memoryAddressDestIn   : hMemAddr;

  // Where a newly accepted result goes; kill dominates a store.
  always_comb begin
    dispatchState = WR_MAIN;
    if (killIn)                    dispatchState = HALTED;
    else if (isMemoryAccessDestIn) dispatchState = STORE;
  end

  // Next-state logic. readyOut is only high in IDLE and in a WR_MAIN with
  // no special write behind it, so accept never collides with pending work.
  always_comb begin
    stateNext  = state;
    retireHeld = 1'b0;
    retireKill = accept && killIn;
    unique case (state)
      IDLE: begin
        if (accept) stateNext = dispatchState;
      end
      WR_MAIN: begin
        if (hSpecValid) begin
          stateNext = WR_SPECIAL;
        end else begin
          retireHeld = 1'b1;
          stateNext  = accept ? dispatchState : IDLE;
        end
      end
      WR_SPECIAL: begin
        retireHeld = 1'b1;
        stateNext  = IDLE;
      end
      STORE: begin
        if (storeAckIn) begin
          if (hSpecValid) begin
            stateNext = WR_SPECIAL;
          end else begin
            retireHeld = 1'b1;
            stateNext  = IDLE;
          end
        end
      end
      HALTED: begin
        stateNext = HALTED;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the coming state.
  always_comb begin
    readyNext     = (stateNext == IDLE) || (stateNext == WR_MAIN && !nSpecValid);
    haltNext      = (stateNext == HALTED);
    wrEnNext      = (stateNext == WR_MAIN) || (stateNext == WR_SPECIAL);
    wrAddrNext    = '0;
    wrDataNext    = '0;
    if (stateNext == WR_MAIN) begin
      wrAddrNext = nDestReg;
      wrDataNext = nAluResult;
    end else if (stateNext == WR_SPECIAL) begin
      wrAddrNext = nDestRegSpecial;
      wrDataNext = nAluResultSpecial;
    end
    storeReqNext  = (stateNext == STORE);
    storeAddrNext = storeReqNext ? nMemAddr   : '0;
    storeDataNext = storeReqNext ? nAluResult : '0;

    // A non-special WR_MAIN can retire in the same edge that accepts a
    // kill, so up to two retirements land at once; the kill is newer.
    countNext = retiredCountOut + 64'(retireHeld) + 64'(retireKill);
    ripNext   = retiredRipOut;
    if (retireKill)      ripNext = currentRipIn;
    else if (retireHeld) ripNext = hRip;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      hDestReg          <= '0;
      hDestRegSpecial   <= '0;
      hSpecValid        <= 1'b0;
      hAluResult        <= '0;
      hAluResultSpecial <= '0;
      hMemAddr          <= '0;
      hRip              <= '0;
      readyOut          <= 1'b1;
      regWriteEnOut     <= 1'b0;
      regWriteAddrOut   <= '0;
      regWriteDataOut   <= '0;
      storeReqOut       <= 1'b0;
      storeAddrOut      <= '0;
      storeDataOut      <= '0;
      haltOut           <= 1'b0;
      retiredCountOut   <= '0;
      retiredRipOut     <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        hDestReg          <= destRegIn;
        hDestRegSpecial   <= destRegSpecialIn;
        hSpecValid        <= destRegSpecialValidIn;
        hAluResult        <= aluResultIn;
        hAluResultSpecial <= aluResultSpecialIn;
        hMemAddr          <= memoryAddressDestIn;
        hRip              <= currentRipIn;
      end
      readyOut        <= readyNext;
      regWriteEnOut   <= wrEnNext;
      regWriteAddrOut <= wrAddrNext;
      regWriteDataOut <= wrDataNext;
      storeReqOut     <= storeReqNext;
      storeAddrOut    <= storeAddrNext;
      storeDataOut    <= storeDataNext;
      haltOut         <= haltNext;
      retiredCountOut <= countNext;
      retiredRipOut   <= ripNext;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
//   Directed scenarios followed by a randomized run. The reference model is
//   a queue of pending actions (register writes and stores): the head of the
//   queue is what the unit must be showing this cycle, and the unit may only
//   take a new result when nothing remains but a final primary write.
// ---------------------------------------------------------------------------
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        validIn;
  logic        readyOut;
  logic [63:0] aluResultIn, aluResultSpecialIn;
  logic [3:0]  destRegIn, destRegSpecialIn;
  logic        destRegSpecialValidIn, isMemoryAccessDestIn;
  logic [63:0] memoryAddressDestIn;
  logic        killIn;
  logic [63:0] currentRipIn;
  logic        regWriteEnOut;
  logic [3:0]  regWriteAddrOut;
  logic [63:0] regWriteDataOut;
  logic        storeReqOut;
  logic [63:0] storeAddrOut, storeDataOut;
  logic        storeAckIn;
  logic        haltOut;
  logic [63:0] retiredCountOut, retiredRipOut;

  writeback_unit dut (
    .clk(clk), .reset(reset), .validIn(validIn), .readyOut(readyOut),
    .aluResultIn(aluResultIn), .aluResultSpecialIn(aluResultSpecialIn),
    .destRegIn(destRegIn), .destRegSpecialIn(destRegSpecialIn),
    .destRegSpecialValidIn(destRegSpecialValidIn),
    .isMemoryAccessDestIn(isMemoryAccessDestIn),
    .memoryAddressDestIn(memoryAddressDestIn), .killIn(killIn),
    .currentRipIn(currentRipIn), .regWriteEnOut(regWriteEnOut),
    .regWriteAddrOut(regWriteAddrOut), .regWriteDataOut(regWriteDataOut),
    .storeReqOut(storeReqOut), .storeAddrOut(storeAddrOut),
    .storeDataOut(storeDataOut), .storeAckIn(storeAckIn), .haltOut(haltOut),
    .retiredCountOut(retiredCountOut), .retiredRipOut(retiredRipOut)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        isStore;
    logic        isSpecial;
    logic [3:0]  regAddr;
    logic [63:0] memAddr;
    logic [63:0] data;
    logic        retire;
    logic [63:0] rip;
  } op_t;

  op_t         q[$];
  logic        mHalted = 1'b0;
  logic [63:0] mCount  = '0;
  logic [63:0] mRip    = '0;

  function automatic logic mReady();
    return !mHalted &&
           (q.size() == 0 || (q.size() == 1 && !q[0].isStore && !q[0].isSpecial));
  endfunction

  task automatic modelEdge(input logic acc);
    op_t o;
    if (reset) begin
      q.delete();
      mHalted = 1'b0;
      mCount  = '0;
      mRip    = '0;
      return;
    end
    // Current action completes: writes always, stores only on ack.
    if (q.size() > 0 && (!q[0].isStore || storeAckIn)) begin
      if (q[0].retire) begin
        mCount = mCount + 1;
        mRip   = q[0].rip;
      end
      q.delete(0);
    end
    if (acc) begin
      if (killIn) begin
        mHalted = 1'b1;
        mCount  = mCount + 1;
        mRip    = currentRipIn;
      end else begin
        o.isStore   = isMemoryAccessDestIn;
        o.isSpecial = 1'b0;
        o.regAddr   = destRegIn;
        o.memAddr   = memoryAddressDestIn;
        o.data      = aluResultIn;
        o.retire    = !destRegSpecialValidIn;
        o.rip       = currentRipIn;
        q.push_back(o);
        if (destRegSpecialValidIn) begin
          o.isStore   = 1'b0;
          o.isSpecial = 1'b1;
          o.regAddr   = destRegSpecialIn;
          o.data      = aluResultSpecialIn;
          o.retire    = 1'b1;
          q.push_back(o);
        end
      end
    end
  endtask

  task automatic compareAll();
    logic expWr, expSt;
    expWr = q.size() > 0 && !q[0].isStore;
    expSt = q.size() > 0 &&  q[0].isStore;
    chk("ready", readyOut, mReady());
    chk("halt", haltOut, mHalted);
    chk("count", retiredCountOut, mCount);
    chk("rip", retiredRipOut, mRip);
    chk("wrEn", regWriteEnOut, expWr);
    if (expWr) begin
      chk("wrAddr", regWriteAddrOut, q[0].regAddr);
      chk("wrData", regWriteDataOut, q[0].data);
    end
    chk("stReq", storeReqOut, expSt);
    if (expSt) begin
      chk("stAddr", storeAddrOut, q[0].memAddr);
      chk("stData", storeDataOut, q[0].data);
    end
  endtask

  // One clock: inputs are stable from the previous negedge; outputs are
  // checked on the following negedge.
  task automatic tick();
    logic acc;
    acc = validIn && mReady();
    @(posedge clk);
    modelEdge(acc);
    @(negedge clk);
    compareAll();
  endtask

  task automatic clrIn();
    validIn               = 1'b0;
    aluResultIn           = '0;
    aluResultSpecialIn    = '0;
    destRegIn             = '0;
    destRegSpecialIn      = '0;
    destRegSpecialValidIn = 1'b0;
    isMemoryAccessDestIn  = 1'b0;
    memoryAddressDestIn   = '0;
    killIn                = 1'b0;
    currentRipIn          = '0;
    storeAckIn            = 1'b0;
  endtask

  task automatic drive(input logic k, input logic m, input logic sv,
                       input logic [3:0] d, input logic [3:0] ds,
                       input logic [63:0] a, input logic [63:0] as,
                       input logic [63:0] ma, input logic [63:0] r);
    validIn               = 1'b1;
    killIn                = k;
    isMemoryAccessDestIn  = m;
    destRegSpecialValidIn = sv;
    destRegIn             = d;
    destRegSpecialIn      = ds;
    aluResultIn           = a;
    aluResultSpecialIn    = as;
    memoryAddressDestIn   = ma;
    currentRipIn          = r;
  endtask

  task automatic doReset();
    clrIn();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clrIn();

    // Reset values.
    doReset();
    chk("rstReady", readyOut, 1);
    chk("rstWrEn", regWriteEnOut, 0);
    chk("rstWrAddr", regWriteAddrOut, 0);
    chk("rstWrData", regWriteDataOut, 0);
    chk("rstStReq", storeReqOut, 0);
    chk("rstStAddr", storeAddrOut, 0);
    chk("rstStData", storeDataOut, 0);
    chk("rstHalt", haltOut, 0);
    chk("rstCount", retiredCountOut, 0);
    chk("rstRip", retiredRipOut, 0);

    // Back-to-back ALU results.
    drive(0, 0, 0, 4'd1, 4'd0, 64'h11, 0, 0, 64'h100); tick();
    chk("b2b1Addr", regWriteAddrOut, 1); chk("b2b1Data", regWriteDataOut, 64'h11);
    chk("b2b1Rdy", readyOut, 1);
    drive(0, 0, 0, 4'd2, 4'd0, 64'h22, 0, 0, 64'h104); tick();
    chk("b2b2Addr", regWriteAddrOut, 2); chk("b2b2Data", regWriteDataOut, 64'h22);
    chk("b2b2Rdy", readyOut, 1);
    drive(0, 0, 0, 4'd3, 4'd0, 64'h33, 0, 0, 64'h108); tick();
    chk("b2b3Addr", regWriteAddrOut, 3); chk("b2b3Data", regWriteDataOut, 64'h33);
    clrIn(); tick();
    chk("b2bCount", retiredCountOut, 3);
    chk("b2bRip", retiredRipOut, 64'h108);
    chk("b2bIdleWr", regWriteEnOut, 0);

    // MUL with special high half, RAX then RDX.
    doReset();
    drive(0, 0, 1, 4'd0, 4'd2, 64'hAAAA, 64'h5555, 0, 64'h200); tick();
    chk("mulMainEn", regWriteEnOut, 1);
    chk("mulMainAddr", regWriteAddrOut, 0);
    chk("mulMainData", regWriteDataOut, 64'hAAAA);
    clrIn(); tick();
    chk("mulSpecEn", regWriteEnOut, 1);
    chk("mulSpecAddr", regWriteAddrOut, 2);
    chk("mulSpecData", regWriteDataOut, 64'h5555);
    chk("mulSpecRdy", readyOut, 0);
    tick();
    chk("mulCount", retiredCountOut, 1);
    chk("mulRdy", readyOut, 1);

    // Store with ack in the fourth request cycle.
    doReset();
    drive(0, 1, 0, 4'd7, 4'd0, 64'hDEADBEEF, 0, 64'h1000, 64'h300); tick();
    clrIn();
    for (int i = 0; i < 4; i++) begin
      chk("stReqHeld", storeReqOut, 1);
      chk("stAddrHeld", storeAddrOut, 64'h1000);
      chk("stDataHeld", storeDataOut, 64'hDEADBEEF);
      chk("stNoWr", regWriteEnOut, 0);
      if (i == 3) storeAckIn = 1'b1;
      tick();
    end
    storeAckIn = 1'b0;
    chk("stDrop", storeReqOut, 0);
    chk("stCount", retiredCountOut, 1);

    // Kill after an ALU result: sticky halt.
    doReset();
    drive(0, 0, 0, 4'd5, 4'd0, 64'h55, 0, 0, 64'h400000); tick();
    drive(1, 0, 0, 4'd6, 4'd0, 64'h66, 0, 0, 64'h400080); tick();
    chk("killHalt", haltOut, 1);
    chk("killRdy", readyOut, 0);
    chk("killRip", retiredRipOut, 64'h400080);
    chk("killCount", retiredCountOut, 2);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 4'(i), 4'd0, 64'(i), 0, 0, 64'h500000);
      tick();
    end
    chk("haltCount", retiredCountOut, 2);
    chk("haltWr", regWriteEnOut, 0);

    // Reset during the second request cycle of a store.
    doReset();
    drive(0, 1, 0, 4'd1, 4'd0, 64'h77, 0, 64'h2000, 64'h600); tick();
    clrIn(); tick();
    chk("rmsReq2", storeReqOut, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rmsReq", storeReqOut, 0);
    chk("rmsCount", retiredCountOut, 0);
    chk("rmsRdy", readyOut, 1);
    storeAckIn = 1'b1; tick(); storeAckIn = 1'b0;
    chk("rmsLateAck", retiredCountOut, 0);

    // Stray ack while idle.
    doReset();
    drive(0, 0, 0, 4'd4, 4'd0, 64'h44, 0, 0, 64'h700); tick();
    clrIn(); tick();
    storeAckIn = 1'b1; tick(); storeAckIn = 1'b0;
    chk("strayCount", retiredCountOut, 1);
    chk("strayRdy", readyOut, 1);
    chk("strayReq", storeReqOut, 0);

    // Randomized run; occasional resets clear halts.
    for (int c = 0; c < 3000; c++) begin
      reset                 = ($urandom_range(0, 99) < 2);
      validIn               = ($urandom_range(0, 99) < 70);
      killIn                = ($urandom_range(0, 99) < 3);
      isMemoryAccessDestIn  = ($urandom_range(0, 99) < 30);
      destRegSpecialValidIn = ($urandom_range(0, 99) < 30);
      destRegIn             = 4'($urandom_range(0, 15));
      destRegSpecialIn      = 4'($urandom_range(0, 15));
      aluResultIn           = {$urandom(), $urandom()};
      aluResultSpecialIn    = {$urandom(), $urandom()};
      memoryAddressDestIn   = {$urandom(), $urandom()};
      currentRipIn          = {$urandom(), $urandom()};
      storeAckIn            = ($urandom_range(0, 99) < 35);
      tick();
    end
    reset = 1'b0;
    clrIn();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
